branch_resolve: RTL

//  Execute-stage branch resolution for RV32I. Consumes the branch_kind_t from branch decode plus operands.

---
 rtl/branch_resolve_if.sv | 51 +++++
 rtl/branch_resolve.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_if.sv
// Branch-kind encoding and the handshake/result bus of the execute-stage branch resolver.
package branch_resolve_pkg;
  typedef enum logic [2:0] {
    bk_beq     = 3'd0,
    bk_bne     = 3'd1,
    bk_blt     = 3'd2,
    bk_bge     = 3'd3,
    bk_bltu    = 3'd4,
    bk_bgeu    = 3'd5,
    bk_invalid = 3'd6
  } branch_kind_t;
endpackage

interface branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import branch_resolve_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  branch_kind_t     in_kind;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_imm;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [XLEN-1:0]  out_next_pc;
  logic             out_illegal;
  logic             out_misalign;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_taken;

  modport master (
    output flush, in_valid, in_kind, in_pc, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_next_pc, out_illegal,
           out_misalign, redirect_valid, redirect_pc, stat_branches, stat_taken
  );

  modport slave (
    input  flush, in_valid, in_kind, in_pc, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_next_pc, out_illegal,
           out_misalign, redirect_valid, redirect_pc, stat_branches, stat_taken
  );
endinterface

// File: rtl/branch_resolve.sv
// RV32I execute-stage branch resolution: condition, target, fetch redirect, wrong-path shadow, stats.
// Optional feature macro: BRANCH_MISALIGN_TRAP_EN (trap taken branches with a non word-aligned target).
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SHADOW_SLOTS = 2,
  parameter int CNT_W        = 32
) (
  input logic            clk,
  input logic            rst,
  branch_resolve_if.slave bus
);

  localparam int              SC_W       = (SHADOW_SLOTS > 0) ? $clog2(SHADOW_SLOTS + 1) : 1;
  localparam logic [SC_W-1:0] SC_RELOAD  = SC_W'(SHADOW_SLOTS);
  localparam logic [SC_W-1:0] SC_ONE     = SC_W'(32'd1);
  localparam logic [SC_W-1:0] SC_ZERO    = SC_W'(32'd0);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam bit              HAS_SHADOW = (SHADOW_SLOTS > 0);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [SC_W-1:0]  r_shadow_cnt;
  logic [SC_W-1:0]  w_shadow_cnt_nx;

  logic             r_out_valid;
  logic             r_taken;
  logic             r_illegal;
  logic             r_misalign;
  logic [XLEN-1:0]  r_target;
  logic [XLEN-1:0]  r_next_pc;
  logic [CNT_W-1:0] r_stat_branches;
  logic [CNT_W-1:0] r_stat_taken;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_deliver;
  logic             w_redirect;
  logic             w_load;
  logic             w_eq;
  logic             w_lt_s;
  logic             w_lt_u;
  logic             w_cond;
  logic             w_illegal;
  logic             w_misalign;
  logic             w_taken;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_next_pc;

  assign w_eq      = (bus.in_rs1 == bus.in_rs2);
  assign w_lt_s    = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
  assign w_lt_u    = (bus.in_rs1 < bus.in_rs2);
  assign w_target  = bus.in_pc + bus.in_imm;
  assign w_next_pc = bus.in_pc + PC_STEP;

  // Branch condition for the incoming op; unknown encodings are reported illegal and never taken.
  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (bus.in_kind)
      bk_beq:     w_cond = w_eq;
      bk_bne:     w_cond = !w_eq;
      bk_blt:     w_cond = w_lt_s;
      bk_bge:     w_cond = !w_lt_s;
      bk_bltu:    w_cond = w_lt_u;
      bk_bgeu:    w_cond = !w_lt_u;
      bk_invalid: w_illegal = 1'b1;
      default:    w_illegal = 1'b1;
    endcase
  end

`ifdef BRANCH_MISALIGN_TRAP_EN
  assign w_misalign = w_cond && (w_target[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  // A trapped branch is reported as not taken, so it neither redirects nor opens a shadow.
  assign w_taken = w_cond && !w_misalign;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_deliver  = r_out_valid && bus.out_ready;
  assign w_redirect = w_deliver && r_taken && !bus.flush;
  assign w_load     = w_accept && (r_state == ST_RUN) && !bus.flush;

  // Result holding register: loads on a resolved accept, clears on delivery or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
      r_misalign  <= 1'b0;
      r_target    <= '0;
      r_next_pc   <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_taken     <= w_taken;
      r_illegal   <= w_illegal;
      r_misalign  <= w_misalign;
      r_target    <= w_target;
      r_next_pc   <= w_next_pc;
    end else if (w_deliver) begin
      r_out_valid <= 1'b0;
    end
  end

  // Shadow FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_shadow_cnt <= SC_ZERO;
    end else begin
      r_state      <= w_state_nx;
      r_shadow_cnt <= w_shadow_cnt_nx;
    end
  end

  // Shadow FSM next state: a redirect reloads the slot count even if a shadow is already running.
  always_comb begin
    w_state_nx      = r_state;
    w_shadow_cnt_nx = r_shadow_cnt;
    if (bus.flush) begin
      w_state_nx      = ST_RUN;
      w_shadow_cnt_nx = SC_ZERO;
    end else if (w_redirect && HAS_SHADOW) begin
      w_state_nx      = ST_SHADOW;
      w_shadow_cnt_nx = SC_RELOAD;
    end else begin
      case (r_state)
        ST_RUN: begin
          w_state_nx = ST_RUN;
        end
        ST_SHADOW: begin
          if (w_accept) begin
            w_shadow_cnt_nx = r_shadow_cnt - SC_ONE;
            if (r_shadow_cnt == SC_ONE) begin
              w_state_nx = ST_RUN;
            end else begin
              w_state_nx = ST_SHADOW;
            end
          end else begin
            w_state_nx = ST_SHADOW;
          end
        end
        default: begin
          w_state_nx      = ST_RUN;
          w_shadow_cnt_nx = SC_ZERO;
        end
      endcase
    end
  end

  // Delivery statistics; they survive flush and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches <= '0;
      r_stat_taken    <= '0;
    end else if (w_deliver) begin
      r_stat_branches <= r_stat_branches + CNT_ONE;
      if (r_taken) begin
        r_stat_taken <= r_stat_taken + CNT_ONE;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_taken      = r_taken;
  assign bus.out_target     = r_target;
  assign bus.out_next_pc    = r_next_pc;
  assign bus.out_illegal    = r_illegal;
  assign bus.out_misalign   = r_misalign;
  assign bus.redirect_valid = w_redirect;
  assign bus.redirect_pc    = r_target;
  assign bus.stat_branches  = r_stat_branches;
  assign bus.stat_taken     = r_stat_taken;

endmodule
